ad_cost_wta: RTL and testbench
==============================

// Module: ad_cost_wta
// PURPOSE
// - Consumes the grey left/right pixel streams and video timing from the half-image splitter (PX_WIDTH=8 build).
// - Computes the absolute-difference matching cost C(x,d)=|L(x)-R(x-d)| for d=0..MAX_DISP-1 per pixel.
// - Selects the winner-take-all disparity, and forwards timing delayed to match.
// - Feeds the SGM path-aggregation stage (cost bus) and the debug disparity display (disp_out).
// PARAMETERS
// - PX_WIDTH   8   bits per grey pixel
// - MAX_DISP   16  number of disparity candidates (>=2)
// - COL_WIDTH  11  column counter width
// - DISP_W     4   disparity index width, $clog2(MAX_DISP)
// PORTS
// - clk         in   1                   pixel clock
// - rst         in   1                   synchronous reset, active-high
// - de_in       in   1                   data enable, 1 = active pixel
// - h_sync_in   in   1                   horizontal sync, passed through
// - v_sync_in   in   1                   vertical sync, 1 = blanking
// - pixel_left  in   PX_WIDTH            left pixel L(x)
// - pixel_right in   PX_WIDTH            right pixel R(x)
// - de_out      out  1                   de_in delayed by 3
// - h_sync_out  out  1                   h_sync_in delayed by 3
// - v_sync_out  out  1                   v_sync_in delayed by 3
// - cost_out    out  MAX_DISP*PX_WIDTH   C(x,d) for d=0..MAX_DISP-1; d=0 in LSBs
// - disp_out    out  DISP_W              argmin_d C(x,d)
// - cost_min    out  PX_WIDTH            C(x,disp_out)
// BEHAVIOUR
// - Reset: every output and pipeline register = 0; column counter = 0; right shift register cleared.
// - Column counter col:
//   - 0 while de_in=0.
//   - Increments on each de_in=1 cycle.
//   - Indexes the pixel currently at the inputs.
// - Right window R[0..MAX_DISP-1]:
//   - Shifts only when de_in=1; R[0]=pixel_right, R[d]=R[d-1].
//   - Holds its contents while de_in=0.
// - Stage 1 (reg):
//   - Latch L, col, timing, and the window view where d=0 is the current input.
// - Stage 2 (reg):
//   - Valid candidates (d <= col): C = |L-R[d]|, computed unsigned at PX_WIDTH+1 bits; the result fits in PX_WIDTH.
//   - Invalid candidates (d > col): C = all-ones. This masks stale data from the previous line, so no per-line clear is needed.
//   - If stage-1 de=0: all C = 0.
// - Stage 3 (reg):
//   - disp_out/cost_min = minimum over d; ties resolve to the lowest d.
//   - If de=0: disp_out = 0 and cost_min = 0.
//   - cost_out is the stage-2 vector, delayed one cycle to align.
// - Latency: exactly 3 clk from input to every output, including sync/de. There is no backpressure; throughput is 1 pixel/clk.
// - Boundaries:
//   - col=0: only d=0 is valid.
//   - col >= MAX_DISP-1: all candidates are valid.
//   - Column counter saturates at 2^COL_WIDTH-1; it never wraps into a false-valid condition.
// - rst mid-frame: outputs go to 0 on the next edge. The first line after release is treated as starting at col=0 when de_in next rises.
// - v_sync_in=1 does not clear state; de_in alone governs validity.
// STRUCTURE
// - Shared package sgm_pkg:
//   - MAX_DISP, PX_WIDTH, DISP_W defaults.
//   - COST_INVALID = {PX_WIDTH{1'b1}}.
//   - Cost-vector slice helper: cost[d*PX_WIDTH +: PX_WIDTH].
// - Sub-module argmin_tree (#N, W):
//   - Combinational reduction tree returning {index, value}, lowest index on ties.
//   - Instantiated in stage 3; reused later by the aggregation stage.
// TESTING
// - Reset: drive pixels with rst=1 for 5 clk -> all outputs 0; de_out=0 for 3 clk after release.
// - Flat line: L=R=0x40 over a 64-px line:
//   - x=0: cost_out d0=0, d1..15=0xFF, disp_out=0.
//   - x>=15: all costs 0, disp_out=0.
// - Known shift: R(x)=x, L(x)=x-5 (x>=5):
//   - For x>=20: cost d5=0, disp_out=5, cost_min=0.
//   - cost d4=1, cost d6=1.
// - Tie: L=10 and the window holds R values 12 at d=3 and d=7, others 50 -> disp_out=3, cost_min=2.
// - Line boundary: line1 ends with R=0, line2 starts with L=0 -> at line2 x=2, costs d3..15=0xFF (not 0).
// - Timing: random de/hsync/vsync pattern -> outputs equal inputs delayed exactly 3 clk.
// - rst mid-line: pulse rst at x=30 -> outputs 0 next clk; the next de rise restarts col at 0.

Source files
------------

// File: rtl/sgm_pkg.sv
// Shared constants, types and helpers for the SGM stereo pipeline (8-bit grey build).
package sgm_pkg;

    localparam int PX_WIDTH  = 8;
    localparam int MAX_DISP  = 16;
    localparam int DISP_W    = $clog2(MAX_DISP);
    localparam int COL_WIDTH = 11;
    localparam int COST_W    = MAX_DISP * PX_WIDTH;

    localparam logic [PX_WIDTH-1:0]  COST_INVALID = {PX_WIDTH{1'b1}};
    localparam logic [COL_WIDTH-1:0] COL_MAX      = {COL_WIDTH{1'b1}};

    typedef logic [PX_WIDTH-1:0] px_t;
    typedef logic [COST_W-1:0]   cost_vec_t;

    // Cost for candidate d out of a packed cost vector (d=0 in the LSBs).
    function automatic px_t cost_at(input cost_vec_t vec, input int unsigned d);
        return vec[d*PX_WIDTH +: PX_WIDTH];
    endfunction

endpackage

// File: rtl/ad_cost_wta_argmin_tree.sv
// Combinational minimum search over N packed W-bit values; ties go to the lowest index.
module argmin_tree #(
    parameter int N  = 16,
    parameter int W  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N*W-1:0] values,
    output logic [IW-1:0]  min_idx,
    output logic [W-1:0]   min_val
);

    localparam int LEAVES = 1 << IW;

    // Heap-ordered binary tree: node k has children 2k and 2k+1, root is node 1.
    logic [W-1:0]  node_val [1:2*LEAVES-1];
    logic [IW-1:0] node_idx [1:2*LEAVES-1];

    genvar gi;
    generate
        for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
            if (gi < N) begin : g_real
                assign node_val[LEAVES+gi] = values[gi*W +: W];
            end else begin : g_pad
                // Padding sits right of every real input, so it can never win a tie.
                assign node_val[LEAVES+gi] = {W{1'b1}};
            end
            assign node_idx[LEAVES+gi] = IW'(gi);
        end

        for (gi = 1; gi < LEAVES; gi++) begin : g_node
            logic take_right;
            // The left child always covers lower indices, so only a strictly smaller right wins.
            assign take_right   = node_val[2*gi+1] < node_val[2*gi];
            assign node_val[gi] = take_right ? node_val[2*gi+1] : node_val[2*gi];
            assign node_idx[gi] = take_right ? node_idx[2*gi+1] : node_idx[2*gi];
        end
    endgenerate

    assign min_idx = node_idx[1];
    assign min_val = node_val[1];

endmodule

// File: rtl/ad_cost_wta.sv
// Absolute-difference matching cost over MAX_DISP disparities with winner-take-all selection.
// Three register stages; timing signals are delayed alongside the data.
module ad_cost_wta
    import sgm_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         de_in,
    input  logic                         h_sync_in,
    input  logic                         v_sync_in,
    input  logic [PX_WIDTH-1:0]          pixel_left,
    input  logic [PX_WIDTH-1:0]          pixel_right,
    output logic                         de_out,
    output logic                         h_sync_out,
    output logic                         v_sync_out,
    output logic [MAX_DISP*PX_WIDTH-1:0] cost_out,
    output logic [DISP_W-1:0]            disp_out,
    output logic [PX_WIDTH-1:0]          cost_min
);

    logic [COL_WIDTH-1:0] col_reg, col_next;
    px_t                  win_reg [MAX_DISP];

    px_t                  s1_left_reg;
    logic [COL_WIDTH-1:0] s1_col_reg;
    logic                 s1_de_reg, s1_hs_reg, s1_vs_reg;

    px_t                  cost_d [MAX_DISP];
    cost_vec_t            s2_cost_reg, s2_cost_next;
    logic                 s2_de_reg, s2_hs_reg, s2_vs_reg;

    logic [DISP_W-1:0]    am_idx;
    px_t                  am_val;

    // Column of the pixel currently at the inputs; saturates so a very long line never wraps.
    always_comb begin
        col_next = '0;
        if (de_in) begin
            col_next = (col_reg == COL_MAX) ? col_reg : col_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg     <= '0;
            s1_left_reg <= '0;
            s1_col_reg  <= '0;
            s1_de_reg   <= 1'b0;
            s1_hs_reg   <= 1'b0;
            s1_vs_reg   <= 1'b0;
        end else begin
            col_reg     <= col_next;
            s1_left_reg <= pixel_left;
            s1_col_reg  <= col_reg;
            s1_de_reg   <= de_in;
            s1_hs_reg   <= h_sync_in;
            s1_vs_reg   <= v_sync_in;
        end
    end

    // The window register doubles as the stage-1 view: after a shift, tap 0 holds the
    // pixel latched with s1_left_reg. When it holds (de=0) stage 2 zeroes the costs anyway.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_DISP; gi++) begin : g_win
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst) begin
                        win_reg[gi] <= '0;
                    end else if (de_in) begin
                        win_reg[gi] <= pixel_right;
                    end
                end
            end else begin : g_tap
                always_ff @(posedge clk) begin
                    if (rst) begin
                        win_reg[gi] <= '0;
                    end else if (de_in) begin
                        win_reg[gi] <= win_reg[gi-1];
                    end
                end
            end
        end

        for (gi = 0; gi < MAX_DISP; gi++) begin : g_cost
            logic [PX_WIDTH:0] diff;
            px_t               abs_diff;
            assign diff     = {1'b0, s1_left_reg} - {1'b0, win_reg[gi]};
            assign abs_diff = diff[PX_WIDTH] ? PX_WIDTH'(-diff) : diff[PX_WIDTH-1:0];
            // Candidates reaching past the line start see stale taps; force them to lose.
            assign cost_d[gi] = !s1_de_reg                     ? '0 :
                                (COL_WIDTH'(gi) <= s1_col_reg) ? abs_diff : COST_INVALID;
        end
    endgenerate

    always_comb begin
        s2_cost_next = '0;
        for (int d = 0; d < MAX_DISP; d++) begin
            s2_cost_next[d*PX_WIDTH +: PX_WIDTH] = cost_d[d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_cost_reg <= '0;
            s2_de_reg   <= 1'b0;
            s2_hs_reg   <= 1'b0;
            s2_vs_reg   <= 1'b0;
        end else begin
            s2_cost_reg <= s2_cost_next;
            s2_de_reg   <= s1_de_reg;
            s2_hs_reg   <= s1_hs_reg;
            s2_vs_reg   <= s1_vs_reg;
        end
    end

    argmin_tree #(
        .N  (MAX_DISP),
        .W  (PX_WIDTH),
        .IW (DISP_W)
    ) u_argmin (
        .values  (s2_cost_reg),
        .min_idx (am_idx),
        .min_val (am_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            de_out     <= 1'b0;
            h_sync_out <= 1'b0;
            v_sync_out <= 1'b0;
            cost_out   <= '0;
            disp_out   <= '0;
            cost_min   <= '0;
        end else begin
            de_out     <= s2_de_reg;
            h_sync_out <= s2_hs_reg;
            v_sync_out <= s2_vs_reg;
            cost_out   <= s2_cost_reg;
            disp_out   <= s2_de_reg ? am_idx : '0;
            cost_min   <= s2_de_reg ? am_val : '0;
        end
    end

endmodule

// File: tb/tb_ad_cost_wta.sv
// Directed bench for ad_cost_wta: hand-computed line patterns, timing alignment and resets.
module tb_ad_cost_wta;
    import sgm_pkg::*;

    logic         clk = 1'b0;
    logic         rst, de_in, h_sync_in, v_sync_in;
    logic [7:0]   pixel_left, pixel_right;
    logic         de_out, h_sync_out, v_sync_out;
    logic [127:0] cost_out;
    logic [3:0]   disp_out;
    logic [7:0]   cost_min;

    ad_cost_wta dut (
        .clk         (clk),
        .rst         (rst),
        .de_in       (de_in),
        .h_sync_in   (h_sync_in),
        .v_sync_in   (v_sync_in),
        .pixel_left  (pixel_left),
        .pixel_right (pixel_right),
        .de_out      (de_out),
        .h_sync_out  (h_sync_out),
        .v_sync_out  (v_sync_out),
        .cost_out    (cost_out),
        .disp_out    (disp_out),
        .cost_min    (cost_min)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         de, hs, vs, chk;
        logic [127:0] cost;
        logic [3:0]   disp;
        logic [7:0]   cmin;
        int           x;
    } exp_t;

    exp_t       q[$];
    logic [7:0] lv [64];
    logic [7:0] rv [64];
    int         tests = 0;
    int         fails = 0;
    int         mode  = 0;

    task automatic eq(input logic [127:0] got, input logic [127:0] want, input string tag);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic exp_t zero_exp(input logic h, input logic v);
        exp_t e;
        e.de = 1'b0; e.hs = h; e.vs = v; e.chk = 1'b1;
        e.cost = '0; e.disp = '0; e.cmin = '0; e.x = -1;
        return e;
    endfunction

    // Expected outputs for pixel x of the line held in lv/rv.
    function automatic exp_t model(input int x);
        exp_t e;
        int   best, c, a;
        e = zero_exp(1'b0, 1'b0);
        e.de = 1'b1; e.x = x;
        best = 256;
        for (int d = 0; d < 16; d++) begin
            if (d <= x) begin
                a = int'(lv[x]) - int'(rv[x-d]);
                c = (a < 0) ? -a : a;
            end else begin
                c = 255;
            end
            e.cost[d*8 +: 8] = 8'(c);
            if (c < best) begin
                best   = c;
                e.disp = 4'(d);
            end
        end
        e.cmin = 8'(best);
        return e;
    endfunction

    task automatic step(input logic r, d, h, v, input logic [7:0] l, rr);
        rst = r; de_in = d; h_sync_in = h; v_sync_in = v;
        pixel_left = l; pixel_right = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        eq(de_out, 0, {tag, " de_out"});
        eq(h_sync_out, 0, {tag, " h_sync_out"});
        eq(v_sync_out, 0, {tag, " v_sync_out"});
        eq(cost_out, 0, {tag, " cost_out"});
        eq(disp_out, 0, {tag, " disp_out"});
        eq(cost_min, 0, {tag, " cost_min"});
    endtask

    task automatic reset_step(input logic d, input logic [7:0] l, rr, input string tag);
        step(1'b1, d, 1'b0, 1'b0, l, rr);
        q.delete();
        check_zero(tag);
        q.push_back(zero_exp(1'b0, 1'b0));
        q.push_back(zero_exp(1'b0, 1'b0));
    endtask

    // Targeted hand-computed checks at specific output pixels.
    task automatic hand(input int ox);
        case (mode)
            1: begin
                if (ox == 0) begin
                    eq(cost_at(cost_out, 0), 8'h00, "flat x0 d0");
                    eq(cost_at(cost_out, 1), 8'hFF, "flat x0 d1");
                    eq(cost_at(cost_out, 15), 8'hFF, "flat x0 d15");
                    eq(disp_out, 0, "flat x0 disp");
                end
                if (ox == 15) eq(cost_out, 0, "flat x15 all costs");
            end
            2: if (ox == 20) begin
                eq(cost_at(cost_out, 5), 8'd0, "shift x20 d5");
                eq(cost_at(cost_out, 4), 8'd1, "shift x20 d4");
                eq(cost_at(cost_out, 6), 8'd1, "shift x20 d6");
                eq(disp_out, 5, "shift x20 disp");
                eq(cost_min, 0, "shift x20 cost_min");
            end
            3: if (ox == 16) begin
                eq(disp_out, 3, "tie disp");
                eq(cost_min, 2, "tie cost_min");
            end
            4: if (ox == 2) begin
                eq(cost_at(cost_out, 2), 8'd100, "bound x2 d2");
                eq(cost_at(cost_out, 3), 8'hFF, "bound x2 d3");
                eq(cost_at(cost_out, 15), 8'hFF, "bound x2 d15");
            end
            5: if (ox == 0) begin
                eq(cost_at(cost_out, 0), 8'h10, "post-rst x0 d0");
                eq(cost_at(cost_out, 1), 8'hFF, "post-rst x0 d1");
                eq(cost_min, 8'h10, "post-rst x0 cost_min");
            end
            default: ;
        endcase
    endtask

    task automatic drive(input logic d, h, v, input logic [7:0] l, rr, input exp_t e);
        exp_t o;
        step(1'b0, d, h, v, l, rr);
        q.push_back(e);
        if (q.size() == 3) begin
            o = q.pop_front();
            eq(de_out, o.de, $sformatf("x%0d de_out", o.x));
            eq(h_sync_out, o.hs, $sformatf("x%0d h_sync_out", o.x));
            eq(v_sync_out, o.vs, $sformatf("x%0d v_sync_out", o.x));
            if (o.chk) begin
                eq(cost_out, o.cost, $sformatf("x%0d cost_out", o.x));
                eq(disp_out, o.disp, $sformatf("x%0d disp_out", o.x));
                eq(cost_min, o.cmin, $sformatf("x%0d cost_min", o.x));
            end
            if (o.x >= 0) hand(o.x);
        end
    endtask

    task automatic run_line(input int n);
        for (int x = 0; x < n; x++) drive(1'b1, 1'b0, 1'b0, lv[x], rv[x], model(x));
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 8'hAA, 8'h55, zero_exp(1'b1, 1'b0));
    endtask

    initial begin
        logic d, h, v;
        exp_t e;

        // Reset held while active pixels stream in.
        for (int i = 0; i < 5; i++) reset_step(1'b1, 8'(i * 7), 8'(i * 3), "reset");

        // Flat line straight out of reset.
        mode = 1;
        for (int x = 0; x < 64; x++) begin lv[x] = 8'h40; rv[x] = 8'h40; end
        run_line(64);
        blank(4);

        // Known shift of 5.
        mode = 2;
        for (int x = 0; x < 64; x++) begin
            rv[x] = 8'(x);
            lv[x] = (x >= 5) ? 8'(x - 5) : 8'd0;
        end
        run_line(64);
        blank(4);

        // Two equal minima at d=3 and d=7 for pixel 16.
        mode = 3;
        for (int x = 0; x < 20; x++) begin
            lv[x] = 8'd10;
            rv[x] = (x == 9 || x == 13) ? 8'd12 : 8'd50;
        end
        run_line(20);
        blank(4);

        // Line boundary: stale zeros in the window must be masked on the next line.
        mode = 0;
        for (int x = 0; x < 20; x++) begin lv[x] = 8'd0; rv[x] = 8'd0; end
        run_line(20);
        blank(3);
        mode = 4;
        for (int x = 0; x < 20; x++) begin lv[x] = 8'd0; rv[x] = 8'd100; end
        run_line(20);
        blank(4);

        // Random timing pattern; data checked only where de is low.
        mode = 0;
        for (int i = 0; i < 200; i++) begin
            d = 1'($urandom_range(0, 1));
            h = 1'($urandom_range(0, 1));
            v = 1'($urandom_range(0, 1));
            e = zero_exp(h, v);
            e.de  = d;
            e.chk = !d;
            drive(d, h, v, 8'($urandom), 8'($urandom), e);
        end
        blank(4);

        // Reset in the middle of a line, then a fresh line.
        for (int x = 0; x < 64; x++) begin lv[x] = 8'h40; rv[x] = 8'h40; end
        for (int x = 0; x < 30; x++) drive(1'b1, 1'b0, 1'b0, lv[x], rv[x], model(x));
        reset_step(1'b1, lv[30], rv[30], "mid-line rst");
        blank(4);
        mode = 5;
        for (int x = 0; x < 20; x++) begin lv[x] = 8'h50; rv[x] = 8'h40; end
        run_line(20);
        blank(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
